menu_selector: RTL and testbench
================================

Name: menu_selector

Overview:
- Battle-menu input stage; sits directly upstream of the menu cursor renderer and drives its 2-bit cursor-position input.
- Debounces the left, right and confirm buttons and moves a 2-bit menu index among FIGHT(0), ACT(1), ITEM(2) and MERCY(3).
- Emits a one-cycle selection strobe with the chosen index to the battle game FSM.
- Holds the position steady while the menu is disabled (enemy turn, dialogue).

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable raw samples required to accept a button level change (2.5 ms at 100 MHz).
- CNT_W, 18: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- RESET_POS, 0: menu index loaded at reset and on every DISABLED->ACTIVE entry (0 = FIGHT).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  level; menu accepts input while high.
- i_left  input  1  raw asynchronous button.
- i_right  input  1  raw asynchronous button.
- i_confirm  input  1  raw asynchronous button.
- o_cursor_position  output  2  current menu index; goes to the cursor renderer.
- o_select_valid  output  1  one-cycle strobe when a selection is committed.
- o_select_index  output  2  committed index; valid while o_select_valid is high, holds its value otherwise.
- o_active  output  1  high in state ACTIVE.

Behaviour:
- Clock and reset: one clock (i_clk). i_rst is asynchronous and active-high.
- Reset values: o_cursor_position=RESET_POS, o_select_valid=0, o_select_index=0, o_active=0, state=DISABLED, all debounced levels=0, all debounce counters=0.
- Input conditioning: each raw button passes through a 2-flop synchronizer, then a debouncer.
  - Counter resets to 0 whenever the synced sample equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge is a one-cycle pulse on the debounced 0->1 transition.
  - Latency from a stable raw edge to the pulse is DEBOUNCE_CYCLES+2 cycles.
- DISABLED:
  - o_active=0 and the position is held.
  - When i_enable=1, move to ACTIVE and load RESET_POS.
- ACTIVE (o_active=1):
  - Confirm pulse: o_select_valid=1 and o_select_index=current position on the next cycle; go to WAIT_RELEASE.
  - Confirm has priority. A left/right pulse in the same cycle is ignored and the committed index is the pre-move value.
  - Right pulse only: position+1. Left pulse only: position-1.
  - Left and right pulses in the same cycle: no move.
  - At the ends (without MENU_WRAP_EN): index 3 plus right stays 3; index 0 plus left stays 0.
  - i_enable=0: go to DISABLED, position held, no strobe.
- WAIT_RELEASE:
  - Stay here until all three debounced levels are 0 and i_enable=1, then go to ACTIVE. The position is kept, not reloaded.
  - i_enable=0: go to DISABLED.
  - Presses made while in this state are discarded.
- Pulse width: o_select_valid is exactly one cycle wide and registered; it is never asserted in DISABLED or WAIT_RELEASE entry+1.
- Reset mid-operation: everything returns immediately to reset values, including the debounce counters.
- Output timing: o_cursor_position is registered and updates one cycle after the accepted pulse.

Optional Feature:
- Macro: MENU_WRAP_EN.
- Defined: moves wrap around modulo 4. Right at 3 goes to 0; left at 0 goes to 3.
- Undefined: moves saturate at 0 and 3 as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package menu_pkg holds:
  - constants MENU_FIGHT=2'd0, MENU_ACT=2'd1, MENU_ITEM=2'd2, MENU_MERCY=2'd3, MENU_LAST=2'd3;
  - the state encoding DISABLED=2'd0, ACTIVE=2'd1, WAIT_RELEASE=2'd2.
- Sub-module button_debounce (parameters DEBOUNCE_CYCLES and CNT_W):
  - contains the synchronizer, the counter and the rising-edge pulse;
  - outputs level and rise;
  - is instantiated three times.

Test Plan:
- Simulation setting: DEBOUNCE_CYCLES=4 throughout.
- Reset then i_enable=1 -> o_active=1 next cycle, o_cursor_position=0, o_select_valid=0.
- Three clean right presses -> position 1, 2, 3. A fourth right -> stays 3 (wrap build: 0). Left at 0 -> stays 0 (wrap build: 3).
- Raw i_right glitch high for 2 cycles -> no position change. A stable press held for 10 cycles -> exactly one increment, DEBOUNCE_CYCLES+2 cycles after the edge.
- At position 2, confirm and right become debounced in the same cycle -> o_select_valid one cycle high with o_select_index=2, position stays 2. Further presses are ignored until all buttons are released, then ACTIVE resumes at 2.
- At position 1, drop i_enable -> o_active=0 and position held at 1; confirm press -> no strobe. Raise i_enable -> position reloads to 0.
- Assert i_rst asynchronously between clock edges while in WAIT_RELEASE -> all outputs return to reset values immediately, and the state reads DISABLED after release.

Source files
------------

// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared constants and state encoding for the battle-menu selector
package menu_pkg;

    localparam logic [1:0] MENU_FIGHT = 2'd0;
    localparam logic [1:0] MENU_ACT   = 2'd1;
    localparam logic [1:0] MENU_ITEM  = 2'd2;
    localparam logic [1:0] MENU_MERCY = 2'd3;
    localparam logic [1:0] MENU_LAST  = 2'd3;

    typedef enum logic [1:0] {
        DISABLED     = 2'd0,
        ACTIVE       = 2'd1,
        WAIT_RELEASE = 2'd2
    } menu_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, stability counter and rising-edge pulse for one button
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_raw    raw asynchronous button input
//   o_level  debounced button level
//   o_rise   one-cycle pulse on the debounced 0->1 transition
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            sync_1 <= i_raw;
            sync_2 <= sync_1;
            o_rise <= 1'b0;
            if (sync_2 == o_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Sample has disagreed with the level long enough: accept it.
                o_level <= sync_2;
                o_rise  <= sync_2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_selector.sv
// rtl/menu_selector.sv - battle-menu input stage: debounced buttons move a 2-bit index and commit a selection
//
// Build option: MENU_WRAP_EN - when defined, left/right moves wrap modulo 4;
// otherwise they saturate at FIGHT(0) and MERCY(3).
//
// Ports:
//   i_clk              system clock
//   i_rst              asynchronous active-high reset
//   i_enable           menu accepts input while high
//   i_left/i_right     raw move buttons
//   i_confirm          raw confirm button
//   o_cursor_position  current menu index (to cursor renderer)
//   o_select_valid     one-cycle strobe when a selection is committed
//   o_select_index     committed index, held between strobes
//   o_active           high while in ACTIVE
module menu_selector
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int RESET_POS       = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_confirm,
    output logic [1:0] o_cursor_position,
    output logic       o_select_valid,
    output logic [1:0] o_select_index,
    output logic       o_active
);

    localparam logic [1:0] RESET_IDX = 2'(RESET_POS);

    logic        left_level, right_level, confirm_level;
    logic        left_rise, right_rise, confirm_rise;
    menu_state_t state;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_left),
        .o_level(left_level), .o_rise(left_rise)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_right),
        .o_level(right_level), .o_rise(right_rise)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_confirm (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_confirm),
        .o_level(confirm_level), .o_rise(confirm_rise)
    );

    // Opposing pulses in the same cycle cancel out.
    function automatic logic [1:0] next_position(input logic [1:0] pos,
                                                 input logic left,
                                                 input logic right);
        logic [1:0] r;
        r = pos;
        if (right && !left) begin
`ifdef MENU_WRAP_EN
            r = pos + 2'd1;
`else
            if (pos != MENU_LAST) r = pos + 2'd1;
`endif
        end else if (left && !right) begin
`ifdef MENU_WRAP_EN
            r = pos - 2'd1;
`else
            if (pos != MENU_FIGHT) r = pos - 2'd1;
`endif
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= DISABLED;
            o_cursor_position <= RESET_IDX;
            o_select_valid    <= 1'b0;
            o_select_index    <= 2'd0;
            o_active          <= 1'b0;
        end else begin
            o_select_valid <= 1'b0;
            case (state)
                DISABLED: begin
                    if (i_enable) begin
                        state             <= ACTIVE;
                        o_active          <= 1'b1;
                        o_cursor_position <= RESET_IDX;
                    end
                end
                ACTIVE: begin
                    if (!i_enable) begin
                        state    <= DISABLED;
                        o_active <= 1'b0;
                    end else if (confirm_rise) begin
                        // Confirm wins; commit the pre-move position.
                        state          <= WAIT_RELEASE;
                        o_active       <= 1'b0;
                        o_select_valid <= 1'b1;
                        o_select_index <= o_cursor_position;
                    end else begin
                        o_cursor_position <= next_position(o_cursor_position, left_rise, right_rise);
                    end
                end
                WAIT_RELEASE: begin
                    if (!i_enable) begin
                        state <= DISABLED;
                    end else if (!left_level && !right_level && !confirm_level) begin
                        state    <= ACTIVE;
                        o_active <= 1'b1;
                    end
                end
                default: begin
                    state    <= DISABLED;
                    o_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_selector.sv
// tb/tb_menu_selector.sv - self-checking bench for menu_selector with scoreboard queues
module tb_menu_selector;

    localparam int DB = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_left = 1'b0;
    logic       i_right = 1'b0;
    logic       i_confirm = 1'b0;
    logic [1:0] o_cursor_position;
    logic       o_select_valid;
    logic [1:0] o_select_index;
    logic       o_active;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] model_pos = 2'd0;
    logic [1:0] exp_pos_q[$];
    logic [1:0] exp_sel_q[$];
    logic [1:0] exp;

    menu_selector #(.DEBOUNCE_CYCLES(DB), .CNT_W(3), .RESET_POS(0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .i_left(i_left), .i_right(i_right), .i_confirm(i_confirm),
        .o_cursor_position(o_cursor_position), .o_select_valid(o_select_valid),
        .o_select_index(o_select_index), .o_active(o_active)
    );

    always #5 i_clk = ~i_clk;

    // Strobe monitor: every high cycle must match one queued expected selection.
    always @(negedge i_clk) begin
        if (!i_rst && o_select_valid) begin
            checks++;
            if (exp_sel_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got index %0d, no selection expected", o_select_index);
            end else begin
                exp = exp_sel_q.pop_front();
                if (o_select_index !== exp) begin
                    errors++;
                    $display("FAIL select_index: got %0d, expected %0d", o_select_index, exp);
                end
            end
        end
    end

    function automatic logic [1:0] model_move(input logic [1:0] pos, input logic right);
        logic [1:0] r;
`ifdef MENU_WRAP_EN
        r = right ? pos + 2'd1 : pos - 2'd1;
`else
        if (right) r = (pos == 2'd3) ? 2'd3 : pos + 2'd1;
        else       r = (pos == 2'd0) ? 2'd0 : pos - 2'd1;
`endif
        return r;
    endfunction

    // Clean press held 10 cycles, then released and allowed to settle.
    task automatic press_move(input logic right);
        @(negedge i_clk);
        if (right) i_right = 1'b1; else i_left = 1'b1;
        model_pos = model_move(model_pos, right);
        exp_pos_q.push_back(model_pos);
        repeat (10) @(negedge i_clk);
        i_right = 1'b0;
        i_left  = 1'b0;
        repeat (12) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks += 4;
        if (o_cursor_position !== 2'd0) begin errors++; $display("FAIL reset_cursor: got %0d, expected 0", o_cursor_position); end
        if (o_select_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b, expected 0", o_select_valid); end
        if (o_select_index !== 2'd0)    begin errors++; $display("FAIL reset_index: got %0d, expected 0", o_select_index); end
        if (o_active !== 1'b0)          begin errors++; $display("FAIL reset_active: got %b, expected 0", o_active); end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_active !== 1'b0) begin errors++; $display("FAIL idle_disabled: got active %b, expected 0", o_active); end
    endtask

    task automatic test_enable();
        i_enable = 1'b1;
        @(negedge i_clk);
        checks += 3;
        if (o_active !== 1'b1)          begin errors++; $display("FAIL enable_active: got %b, expected 1", o_active); end
        if (o_cursor_position !== 2'd0) begin errors++; $display("FAIL enable_cursor: got %0d, expected 0", o_cursor_position); end
        if (o_select_valid !== 1'b0)    begin errors++; $display("FAIL enable_valid: got %b, expected 0", o_select_valid); end
        model_pos = 2'd0;
    endtask

    task automatic test_moves();
        for (int i = 0; i < 4; i++) begin
            press_move(1'b1);
            exp = exp_pos_q.pop_front();
            checks++;
            if (o_cursor_position !== exp) begin errors++; $display("FAIL right_move_%0d: got %0d, expected %0d", i, o_cursor_position, exp); end
        end
        while (model_pos != 2'd0) begin
            press_move(1'b0);
            exp = exp_pos_q.pop_front();
            checks++;
            if (o_cursor_position !== exp) begin errors++; $display("FAIL left_walk: got %0d, expected %0d", o_cursor_position, exp); end
        end
        press_move(1'b0);
        exp = exp_pos_q.pop_front();
        checks++;
        if (o_cursor_position !== exp) begin errors++; $display("FAIL left_at_zero: got %0d, expected %0d", o_cursor_position, exp); end
        while (model_pos != 2'd0) begin
            press_move(1'b1);
            exp = exp_pos_q.pop_front();
            checks++;
            if (o_cursor_position !== exp) begin errors++; $display("FAIL renormalise: got %0d, expected %0d", o_cursor_position, exp); end
        end
    endtask

    task automatic test_debounce();
        @(negedge i_clk);
        i_right = 1'b1;
        repeat (2) @(negedge i_clk);
        i_right = 1'b0;
        repeat (12) @(negedge i_clk);
        checks++;
        if (o_cursor_position !== model_pos) begin errors++; $display("FAIL glitch: got %0d, expected %0d", o_cursor_position, model_pos); end
        // Pulse appears after DB+2 edges; the registered cursor one edge later.
        i_right = 1'b1;
        repeat (DB + 2) @(negedge i_clk);
        checks++;
        if (o_cursor_position !== model_pos) begin errors++; $display("FAIL latency_early: got %0d, expected %0d", o_cursor_position, model_pos); end
        @(negedge i_clk);
        model_pos = model_move(model_pos, 1'b1);
        checks++;
        if (o_cursor_position !== model_pos) begin errors++; $display("FAIL latency_edge: got %0d, expected %0d", o_cursor_position, model_pos); end
        repeat (10 - DB - 3) @(negedge i_clk);
        i_right = 1'b0;
        repeat (12) @(negedge i_clk);
        checks++;
        if (o_cursor_position !== model_pos) begin errors++; $display("FAIL single_increment: got %0d, expected %0d", o_cursor_position, model_pos); end
    endtask

    task automatic test_confirm_priority();
        while (model_pos != 2'd2) begin
            press_move(1'b1);
            exp = exp_pos_q.pop_front();
            checks++;
            if (o_cursor_position !== exp) begin errors++; $display("FAIL reach_two: got %0d, expected %0d", o_cursor_position, exp); end
        end
        @(negedge i_clk);
        i_confirm = 1'b1;
        i_right   = 1'b1;
        exp_sel_q.push_back(2'd2);
        repeat (10) @(negedge i_clk);
        checks += 3;
        if (o_cursor_position !== 2'd2) begin errors++; $display("FAIL priority_cursor: got %0d, expected 2", o_cursor_position); end
        if (o_active !== 1'b0)          begin errors++; $display("FAIL wait_release_active: got %b, expected 0", o_active); end
        if (exp_sel_q.size() != 0)      begin errors++; $display("FAIL priority_strobe: pending %0d, expected 0", exp_sel_q.size()); end
        i_right = 1'b0;
        i_left  = 1'b1;
        repeat (10) @(negedge i_clk);
        checks += 2;
        if (o_cursor_position !== 2'd2) begin errors++; $display("FAIL wait_ignore_left: got %0d, expected 2", o_cursor_position); end
        if (o_active !== 1'b0)          begin errors++; $display("FAIL wait_still_held: got %b, expected 0", o_active); end
        i_left    = 1'b0;
        i_confirm = 1'b0;
        repeat (12) @(negedge i_clk);
        checks += 2;
        if (o_active !== 1'b1)          begin errors++; $display("FAIL resume_active: got %b, expected 1", o_active); end
        if (o_cursor_position !== 2'd2) begin errors++; $display("FAIL resume_cursor: got %0d, expected 2", o_cursor_position); end
    endtask

    task automatic test_disable();
        press_move(1'b0);
        exp = exp_pos_q.pop_front();
        checks++;
        if (o_cursor_position !== exp) begin errors++; $display("FAIL reach_one: got %0d, expected %0d", o_cursor_position, exp); end
        i_enable = 1'b0;
        @(negedge i_clk);
        checks += 2;
        if (o_active !== 1'b0)          begin errors++; $display("FAIL disable_active: got %b, expected 0", o_active); end
        if (o_cursor_position !== 2'd1) begin errors++; $display("FAIL disable_hold: got %0d, expected 1", o_cursor_position); end
        i_confirm = 1'b1;
        repeat (10) @(negedge i_clk);
        i_confirm = 1'b0;
        repeat (12) @(negedge i_clk);
        checks++;
        if (o_cursor_position !== 2'd1) begin errors++; $display("FAIL disabled_confirm_hold: got %0d, expected 1", o_cursor_position); end
        i_enable = 1'b1;
        @(negedge i_clk);
        model_pos = 2'd0;
        checks += 2;
        if (o_active !== 1'b1)          begin errors++; $display("FAIL reenable_active: got %b, expected 1", o_active); end
        if (o_cursor_position !== 2'd0) begin errors++; $display("FAIL reenable_reload: got %0d, expected 0", o_cursor_position); end
    endtask

    task automatic test_async_reset();
        press_move(1'b1);
        exp = exp_pos_q.pop_front();
        checks++;
        if (o_cursor_position !== exp) begin errors++; $display("FAIL pre_reset_move: got %0d, expected %0d", o_cursor_position, exp); end
        @(negedge i_clk);
        i_confirm = 1'b1;
        exp_sel_q.push_back(model_pos);
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_active !== 1'b0) begin errors++; $display("FAIL in_wait_release: got %b, expected 0", o_active); end
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        checks += 4;
        if (o_cursor_position !== 2'd0) begin errors++; $display("FAIL async_cursor: got %0d, expected 0", o_cursor_position); end
        if (o_select_valid !== 1'b0)    begin errors++; $display("FAIL async_valid: got %b, expected 0", o_select_valid); end
        if (o_select_index !== 2'd0)    begin errors++; $display("FAIL async_index: got %0d, expected 0", o_select_index); end
        if (o_active !== 1'b0)          begin errors++; $display("FAIL async_active: got %b, expected 0", o_active); end
        i_confirm = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        model_pos = 2'd0;
        checks += 2;
        if (o_active !== 1'b1)          begin errors++; $display("FAIL post_reset_active: got %b, expected 1", o_active); end
        if (o_cursor_position !== 2'd0) begin errors++; $display("FAIL post_reset_cursor: got %0d, expected 0", o_cursor_position); end
        press_move(1'b1);
        exp = exp_pos_q.pop_front();
        checks++;
        if (o_cursor_position !== exp) begin errors++; $display("FAIL post_reset_move: got %0d, expected %0d", o_cursor_position, exp); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_moves();
        test_debounce();
        test_confirm_priority();
        test_disable();
        test_async_reset();
        repeat (5) @(negedge i_clk);
        checks++;
        if (exp_sel_q.size() != 0) begin errors++; $display("FAIL missing_strobes: pending %0d, expected 0", exp_sel_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
